// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch request/response and program-load handshake bundle.
// master drives requests, response-ready, flush and loads; slave (the memory) drives the rest.
interface imem_fetch_if #(parameter int N = 32, parameter int ADDR_W = 7);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic              flush;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [N-1:0]      ld_data;
  modport master (
    output req_valid, req_addr, rsp_ready, flush, ld_valid, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, ld_ready
  );
  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, ld_valid, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, ld_ready
  );
endinterface

// File: rtl/imem_fetch.sv
// imem_fetch: instruction memory with clear-on-reset sweep, 1-cycle fetch and program load.
// Ports: clk, reset (async, active-low), bus (imem_fetch_if.slave: req/rsp/flush/ld),
//        init_done (clear sweep finished), fetch_cnt (saturating count of consumed responses).
// Optional IMEM_PARITY_EN: stores an even-parity bit per word and reports mismatches on rsp_err.
module imem_fetch #(
  parameter int N = 32,
  parameter int ADDR_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  imem_fetch_if.slave bus,
  output logic        init_done,
  output logic [31:0] fetch_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [N-1:0]      mem [DEPTH];
  logic              accept;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [N-1:0]      wd;
  assign init_done     = state == RUN;
  assign bus.ld_ready  = state == RUN;
  assign bus.req_ready = state == RUN && !bus.flush && (!bus.rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  // INIT owns the write port for the clear sweep; loads only land in RUN
  assign we = state == INIT || bus.ld_valid;
  assign wa = state == INIT ? cnt : bus.ld_addr;
  assign wd = state == INIT ? '0 : bus.ld_data;
`ifdef IMEM_PARITY_EN
  logic par [DEPTH];
  logic err;
  always_ff @(posedge clk)
    if (we) begin
      mem[wa] <= wd;
      par[wa] <= ^wd;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) err <= 1'b0;
    else if (accept) err <= (^mem[bus.req_addr]) != par[bus.req_addr];
  assign bus.rsp_err = err;
`else
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign bus.rsp_err = 1'b0;
`endif
  // the read below samples mem before this edge's write lands, giving read-first behaviour
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= INIT;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_addr  <= '0;
      fetch_cnt     <= '0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt + ADDR_W'(1);
        if (&cnt) state <= RUN;
      end
      if (accept) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= mem[bus.req_addr];
        bus.rsp_addr  <= bus.req_addr;
      end else if (bus.flush || bus.rsp_ready) bus.rsp_valid <= 1'b0;
      if (bus.rsp_valid && bus.rsp_ready && !bus.flush && !(&fetch_cnt)) fetch_cnt <= fetch_cnt + 32'd1;
    end
endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter N, default 32: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 7: word-address width; DEPTH = 2**ADDR_W words (default 128).
REQ-003 Ports, clock and reset first:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when high with req_valid.
- req_addr  in  ADDR_W  fetch word address.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  N  fetched instruction word.
- rsp_addr  out  ADDR_W  address of rsp_data.
- rsp_err  out  1  parity error on rsp_data.
- flush  in  1  discard the pending response and block new requests this cycle.
- ld_valid  in  1  program-load write valid.
- ld_ready  out  1  load write accepted.
- ld_addr  in  ADDR_W  load word address.
- ld_data  in  N  load word.
- init_done  out  1  memory clear sweep finished.
- fetch_cnt  out  32  count of responses consumed.

Function
REQ-004 Two-state FSM: INIT, RUN. Reset entry state is INIT.
REQ-005 INIT: an ADDR_W-bit counter writes zero to one word per cycle, from address 0 to DEPTH-1; after writing DEPTH-1 the FSM enters RUN on the next edge, so INIT lasts exactly DEPTH cycles.
REQ-006 INIT: req_ready=0, ld_ready=0, init_done=0. RUN: init_done=1.
REQ-007 RUN: ld_ready=1. A write with ld_valid=1 commits ld_data to ld_addr at the edge.
REQ-008 RUN: req_ready = !flush && (!rsp_valid || rsp_ready).
REQ-009 Read latency is 1 cycle. A request accepted at edge k gives, after edge k: rsp_valid=1, rsp_data=mem[req_addr], rsp_addr=req_addr.
REQ-010 Read-first: a load write and an accepted read to the same address at the same edge return the old word; the new word is visible from the next request.
REQ-011 While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_addr and rsp_err hold stable.
REQ-012 rsp_valid clears at the edge where rsp_ready=1 and no new request is accepted.
REQ-013 Back-to-back: with rsp_ready=1 and a request every cycle, throughput is one word per cycle.
REQ-014 flush=1 clears rsp_valid at the next edge, regardless of rsp_ready. No request is accepted in a flush cycle.
REQ-015 flush has no effect on a load write in the same cycle.
REQ-016 fetch_cnt increments by 1 when rsp_valid && rsp_ready && !flush, and saturates at 32'hFFFF_FFFF.
REQ-017 Addresses are ADDR_W wide, so every address is in range; there is no wrap logic.

Reset
REQ-018 Asserting reset at any time, including mid-INIT or mid-transfer, immediately sets: state=INIT, INIT counter=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, fetch_cnt=0, init_done=0, req_ready=0, ld_ready=0.
REQ-019 After reset is released, the full DEPTH-cycle clear sweep repeats; previously loaded contents are lost.

Configuration
REQ-020 Macro IMEM_PARITY_EN.
- Defined: each word stores one extra even-parity bit, computed on load and on INIT writes. On read, rsp_err=1 when the stored parity mismatches the parity of the data; rsp_err is registered and aligned with rsp_data.
- Not defined: no parity storage; rsp_err is tied to 0.
- All other behaviour is identical in both builds.

Verification
REQ-021 Reset released, ADDR_W=7 -> init_done rises exactly 128 cycles later. Requests to addresses 0, 64 and 127 then return 32'h0.
REQ-022 After INIT: load 32'h8b1f03ff at 5 and 32'hf8000001 at 6, then read 5 and 6 back-to-back with rsp_ready=1 -> two consecutive rsp_valid cycles with those words and rsp_addr 5, 6. fetch_cnt=2.
REQ-023 Read 6, then hold rsp_ready=0 for 3 cycles -> rsp_data stays 32'hf8000001 and req_ready=0 during the stall. After rsp_ready=1, fetch_cnt increments once.
REQ-024 In one cycle, load 32'hcb050083 at 6 and read 6 -> response 32'hf8000001. A following read of 6 -> 32'hcb050083.
REQ-025 Response pending, flush=1 with req_valid=1 -> rsp_valid=0 next cycle, no request accepted, fetch_cnt unchanged.
REQ-026 Reset asserted during INIT at counter 40, then released -> 128 more cycles until init_done. With IMEM_PARITY_EN, a forced stored-parity flip at address 5 -> rsp_err=1 on a read of 5.
